// File: rtl/bist_fault_map.sv
// BIST pattern checker with per-channel fault classification.
// It regenerates the transmitter's LFSR pattern and compares it with the link.
// Each channel that mismatched is reported as stuck-high, stuck-low or
// intermittent once the run completes.
module bist_fault_map #(
  parameter int          TEST_CHANNELS = 70,
  parameter logic [31:0] SEED          = 32'hdeadbeef,
  parameter int          TEST_CASES    = 1000,
  parameter int          LINK_LATENCY  = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [TEST_CHANNELS-1:0] input_channels,
  output logic                     busy,
  output logic                     done,
  output logic                     failed,
  output logic [TEST_CHANNELS-1:0] stuck_hi,
  output logic [TEST_CHANNELS-1:0] stuck_lo,
  output logic [TEST_CHANNELS-1:0] intermittent,
  output logic [15:0]              err_cycles
);

  localparam int CW = $clog2(TEST_CASES + 1);
  localparam int LW = (LINK_LATENCY > 1) ? $clog2(LINK_LATENCY + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t                   state, state_nxt;
  logic [31:0]              lfsr;
  logic [CW-1:0]            case_cnt;
  logic [LW-1:0]            lat_cnt;
  logic [TEST_CHANNELS-1:0] saw0, saw1, mm;
  logic [TEST_CHANNELS-1:0] saw0_n, saw1_n, mm_n;
  logic [TEST_CHANNELS-1:0] exp_word, mm_word;
  logic [15:0]              err_cnt, err_n;
  logic [TEST_CHANNELS-1:0] sh_q, sl_q, int_q;
  logic                     fail_q;
  logic [15:0]              err_q;
  logic                     run_start, last_case, lat_last;

  assign run_start = start && (state == S_IDLE || state == S_DONE);
  assign last_case = (case_cnt == CW'(TEST_CASES - 1));
  assign lat_last  = (lat_cnt == LW'(LINK_LATENCY - 1));

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; zero latency skips WAIT entirely
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_nxt = (LINK_LATENCY == 0) ? S_CHECK : S_WAIT;
      S_WAIT:         if (lat_last) state_nxt = S_CHECK;
      S_CHECK:        if (last_case) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state and registered results
  always_comb begin
    busy         = (state == S_WAIT) || (state == S_CHECK);
    done         = (state == S_DONE);
    failed       = done & fail_q;
    stuck_hi     = done ? sh_q  : '0;
    stuck_lo     = done ? sl_q  : '0;
    intermittent = done ? int_q : '0;
    err_cycles   = done ? err_q : '0;
  end

  // Expected word: LFSR replicated across channels, odd 32-bit groups inverted
  always_comb begin
    exp_word = '0;
    for (int unsigned i = 0; i < TEST_CHANNELS; i++)
      exp_word[i] = lfsr[i % 32] ^ 1'(i / 32);
    mm_word = input_channels ^ exp_word;
    saw0_n  = saw0 | ~input_channels;
    saw1_n  = saw1 | input_channels;
    mm_n    = mm | mm_word;
    err_n   = ((|mm_word) && (err_cnt != 16'hffff)) ? err_cnt + 16'd1 : err_cnt;
  end

  // Pattern generator, counters, sticky flags and result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr     <= '0;
      case_cnt <= '0;
      lat_cnt  <= '0;
      saw0     <= '0;
      saw1     <= '0;
      mm       <= '0;
      err_cnt  <= '0;
      sh_q     <= '0;
      sl_q     <= '0;
      int_q    <= '0;
      fail_q   <= 1'b0;
      err_q    <= '0;
    end else if (run_start) begin
      lfsr     <= SEED;
      case_cnt <= '0;
      lat_cnt  <= '0;
      saw0     <= '0;
      saw1     <= '0;
      mm       <= '0;
      err_cnt  <= '0;
      sh_q     <= '0;
      sl_q     <= '0;
      int_q    <= '0;
      fail_q   <= 1'b0;
      err_q    <= '0;
    end else if (state == S_WAIT) begin
      lat_cnt <= lat_cnt + LW'(1);
    end else if (state == S_CHECK) begin
      lfsr     <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      case_cnt <= case_cnt + CW'(1);
      saw0     <= saw0_n;
      saw1     <= saw1_n;
      mm       <= mm_n;
      err_cnt  <= err_n;
      // Final compare folds into the captured results on the same edge
      if (last_case) begin
        sh_q   <= mm_n & ~saw0_n;
        sl_q   <= mm_n & ~saw1_n;
        int_q  <= mm_n & saw0_n & saw1_n;
        fail_q <= |mm_n;
        err_q  <= err_n;
      end
    end
  end

endmodule
